// File: rtl/sine_adc_capture.sv
// Sine receive path: hysteretic rising-crossing detector, period / peak measurement and triggered capture buffer.
// Define SINE_ADC_DC_EST_EN to build the (pk_max + pk_min) / 2 DC estimator; otherwise dc_est is tied to MID.
module sine_adc_capture #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 64,
  parameter int MID    = 2048,
  parameter int HYST   = 64,
  parameter int PER_W  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [PER_W-1:0]  period,
  output logic              period_valid,
  output logic              period_ovf,
  output logic [DATA_W-1:0] pk_max,
  output logic [DATA_W-1:0] pk_min,
  output logic [DATA_W-1:0] dc_est
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPT, S_DONE} state_t;

  localparam logic [DATA_W-1:0] MID_C   = DATA_W'(MID);
  localparam logic [DATA_W-1:0] ARM_C   = DATA_W'(MID - HYST);
  localparam logic [PER_W-1:0]  CNT_MAX = '1;
  localparam logic [AW-1:0]     LAST_A  = AW'(DEPTH - 1);

  state_t              state_q;
  logic                busy_q, done_q;
  logic [AW-1:0]       waddr_q;
  logic                arm_low_q, first_seen_q;
  logic [PER_W-1:0]    cnt_q, period_q;
  logic                pv_q, ovf_q;
  logic [DATA_W-1:0]   run_max_q, run_min_q, pk_max_q, pk_min_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc, xing;
  logic [PER_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   max_d, min_d;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;

  assign acc   = sample_valid & en;
  assign xing  = acc & arm_low_q & (sample_data >= MID_C);
  assign cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  assign max_d = (sample_data > run_max_q) ? sample_data : run_max_q;
  assign min_d = (sample_data < run_min_q) ? sample_data : run_min_q;

  // Crossing detector and per-period measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_low_q    <= 1'b0;
      first_seen_q <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      pv_q         <= 1'b0;
      ovf_q        <= 1'b0;
      run_max_q    <= '0;
      run_min_q    <= '1;
      pk_max_q     <= '0;
      pk_min_q     <= '1;
    end else begin
      pv_q <= 1'b0;
      if (acc) begin
        if (sample_data <= ARM_C) arm_low_q <= 1'b1;
        else if (xing)            arm_low_q <= 1'b0;
        if (xing) begin
          first_seen_q <= 1'b1;
          cnt_q        <= '0;
          run_max_q    <= sample_data;
          run_min_q    <= sample_data;
          if (first_seen_q) begin
            period_q <= cnt_d;
            pk_max_q <= max_d;
            pk_min_q <= min_d;
            pv_q     <= 1'b1;
          end
        end else begin
          cnt_q     <= cnt_d;
          run_max_q <= max_d;
          run_min_q <= min_d;
          if (cnt_d == CNT_MAX) ovf_q <= 1'b1;
        end
      end
    end
  end

`ifdef SINE_ADC_DC_EST_EN
  logic [DATA_W:0]   dc_sum;
  logic [DATA_W-1:0] dc_q;
  assign dc_sum = {1'b0, max_d} + {1'b0, min_d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   dc_q <= MID_C;
    else if (xing & first_seen_q) dc_q <= dc_sum[DATA_W:1];
  end
  assign dc_est = dc_q;
`else
  assign dc_est = MID_C;
`endif

  // Capture FSM; a start coinciding with a crossing in IDLE only arms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_ARMED;
          busy_q  <= 1'b1;
        end
        S_ARMED: if (xing) begin
          state_q <= S_CAPT;
          waddr_q <= AW'(1);
        end
        S_CAPT: if (acc) begin
          waddr_q <= waddr_q + 1'b1;
          if (waddr_q == LAST_A) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: if (start) begin
          state_q <= S_ARMED;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          waddr_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en   = (xing & (state_q == S_ARMED)) | (acc & (state_q == S_CAPT));
  assign wr_addr = (state_q == S_ARMED) ? '0 : waddr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[rd_addr];
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_data      = rd_data_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign period_ovf   = ovf_q;
  assign pk_max       = pk_max_q;
  assign pk_min       = pk_min_q;

endmodule

// File: tb/tb_sine_adc_capture.sv
// Randomized bench for sine_adc_capture against a sample-history reference model.
module tb_sine_adc_capture;
  localparam int DEPTH = 64;

  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b1, sample_valid = 1'b0, start = 1'b0;
  logic [11:0] sample_data = '0;
  logic [5:0]  rd_addr = '0;
  logic        busy, done, period_valid, period_ovf;
  logic [11:0] rd_data, pk_max, pk_min, dc_est;
  logic [15:0] period;

  always #5 clk = ~clk;

  sine_adc_capture #(.DATA_W(12), .DEPTH(DEPTH), .MID(2048), .HYST(64), .PER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid), .sample_data(sample_data),
    .start(start), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .period(period), .period_valid(period_valid), .period_ovf(period_ovf),
    .pk_max(pk_max), .pk_min(pk_min), .dc_est(dc_est)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: keeps every accepted sample since reset and derives results from that history.
  int smp[$];
  int cap[$];
  bit arm_m, first_m, ovf_m, pv_m;
  int last_m, per_m, max_m, min_m, dc_m;
  int cst; // 0 idle, 1 armed, 2 capturing, 3 done

  function automatic void mdl_reset();
    smp.delete();
    arm_m = 0; first_m = 0; ovf_m = 0; pv_m = 0;
    last_m = -1; per_m = 0; max_m = 0; min_m = 4095; dc_m = 2048;
    cst = 0;
  endfunction

  function automatic void mdl_step(input bit acc, input int s, input bit st);
    int pre = cst;
    bit x = 0;
    pv_m = 0;
    if (acc) begin
      int idx = smp.size();
      smp.push_back(s);
      x = arm_m && (s >= 2048);
      if (s <= 2048 - 64) arm_m = 1;
      else if (x)         arm_m = 0;
      if (x) begin
        if (first_m) begin
          per_m = (idx - last_m > 65535) ? 65535 : idx - last_m;
          max_m = 0; min_m = 4095;
          for (int i = last_m; i <= idx; i++) begin
            if (smp[i] > max_m) max_m = smp[i];
            if (smp[i] < min_m) min_m = smp[i];
          end
`ifdef SINE_ADC_DC_EST_EN
          dc_m = (max_m + min_m) / 2;
`else
          dc_m = 2048;
`endif
          pv_m = 1;
        end
        first_m = 1;
        last_m  = idx;
      end else if (idx - last_m >= 65535) ovf_m = 1;
      if (pre == 1 && x) begin
        cap.delete(); cap.push_back(s); cst = 2;
      end else if (pre == 2) begin
        cap.push_back(s);
        if (cap.size() == DEPTH) cst = 3;
      end
    end
    if (st && (pre == 0 || pre == 3)) cst = 1;
  endfunction

  task automatic drive(input int s, input bit v, input bit e, input bit st, input bit quiet);
    sample_data = 12'(s); sample_valid = v; en = e; start = st;
    @(posedge clk); #1;
    sample_valid = 0; en = 1; start = 0;
    mdl_step(v && e, s, st);
    if (!quiet) begin
      chk("period_valid", period_valid, pv_m);
      chk("busy", busy, (cst == 1 || cst == 2));
      chk("done", done, cst == 3);
      if (pv_m) begin
        chk("period", period, per_m);
        chk("pk_max", pk_max, max_m);
        chk("pk_min", pk_min, min_m);
        chk("dc_est", dc_est, dc_m);
        chk("period_ovf", period_ovf, ovf_m);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pv"}, period_valid, 0);
    chk({tag, "_ovf"}, period_ovf, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_pkmax"}, pk_max, 0);
    chk({tag, "_pkmin"}, pk_min, 12'hfff);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_dc"}, dc_est, 2048);
  endtask

  function automatic int sine_code(input int k);
    real r = 2047.5 + 2047.5 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
    int  v = $rtoi(r + 0.5) + int'($urandom_range(0, 4)) - 2;
    if (v < 0)    v = 0;
    if (v > 4095) v = 4095;
    return v;
  endfunction

  function automatic int noisy();
    return ($urandom_range(0, 1) != 0) ? 2060 : 2040;
  endfunction

  initial begin
    int ph, k;
    bit paused;
    mdl_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    rst_n = 1;

    // Free-running sine, four periods, one sample per 4 clocks
    ph = int'($urandom_range(0, 63));
    for (int i = 0; i < 256; i++) begin
      drive(sine_code(ph + i), 1, 1, 0, 0);
      idle(3);
    end

    // Start coincident with a crossing only arms; the next crossing triggers
    drive(1000, 1, 1, 0, 0);
    drive(3000, 1, 1, 1, 0);
    k = int'($urandom_range(0, 63));
    paused = 0;
    for (int n = 0; n < 600 && cst != 3; n++) begin
      if (cst == 2 && cap.size() == 20 && !paused) begin
        for (int c = 0; c < 50; c++) drive(int'($urandom_range(0, 4095)), c[0], 0, 0, 0);
        paused = 1;
      end
      drive(sine_code(k + n), 1, 1, 0, 0);
      idle(3);
    end
    chk("cap_done", done, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 6'(a);
      @(posedge clk); #1;
      chk($sformatf("rd[%0d]", a), rd_data, (a < cap.size()) ? cap[a] : -1);
    end

    // Chatter around midscale never re-arms: no periods, capture stays armed
    repeat (10) begin drive(noisy(), 1, 1, 0, 0); idle(1); end
    drive(0, 0, 1, 1, 0);
    repeat (200) begin drive(noisy(), 1, 1, 0, 0); idle(1); end

    // Asynchronous reset in the middle of a capture
    drive(1000, 1, 1, 0, 0);
    drive(3000, 1, 1, 0, 0);
    repeat (5) drive(int'($urandom_range(0, 4095)), 1, 1, 0, 0);
    #2 rst_n = 0;
    #1 chk_reset_vals("midrst");
    mdl_reset();
    @(posedge clk); #1 rst_n = 1;

    // Period counter saturation
    drive(1000, 1, 1, 0, 0);
    drive(3000, 1, 1, 0, 0);
    chk("ovf_early", period_ovf, ovf_m);
    for (int i = 0; i < 65540; i++) drive(1000, 1, 1, 0, 1);
    chk("ovf_sticky", period_ovf, ovf_m);
    drive(3000, 1, 1, 0, 0);
    chk("ovf_period", period, 65535);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
